// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way request arbiter.
package arb_pkg;

  localparam int N_REQ_C = 4;
  localparam int IDX_W_C = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arbState_e;

  function automatic logic [N_REQ_C-1:0] oneHot(input logic [IDX_W_C-1:0] idx);
    logic [N_REQ_C-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/req_arbiter_4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface req_arbiter_4_if;
  import arb_pkg::*;

  logic [N_REQ_C-1:0] req;
  logic               rr_en;
  logic [N_REQ_C-1:0] gnt;
  logic [IDX_W_C-1:0] gnt_id;
  logic               gnt_valid;
  logic               timeout;

  modport master (output req, rr_en, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input req, rr_en, output gnt, gnt_id, gnt_valid, timeout);

endinterface

// File: rtl/arb_pick.sv
// Combinational winner selection: fixed priority (highest index) or
// round-robin starting just after the last owner.
module arb_pick
  import arb_pkg::*;
(
  input  logic [N_REQ_C-1:0] i_req,
  input  logic [IDX_W_C-1:0] i_ptr,
  input  logic               i_rr_en,
  output logic               o_any,
  output logic [IDX_W_C-1:0] o_idx
);

  // Both loops let the preferred candidate overwrite the others; in the
  // round-robin loop k wraps to ptr itself at k == N_REQ_C, so it ranks last.
  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    if (i_rr_en) begin
      for (int k = N_REQ_C; k >= 1; k--) begin
        if (i_req[i_ptr + IDX_W_C'(k)]) o_idx = i_ptr + IDX_W_C'(k);
      end
    end else begin
      for (int i = 0; i < N_REQ_C; i++) begin
        if (i_req[i]) o_idx = IDX_W_C'(i);
      end
    end
  end

endmodule

// File: rtl/req_arbiter_4.sv
// Four-requester arbiter with non-preemptive grants, optional hold limit
// and a one-cycle dead slot between owners.
module req_arbiter_4
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  req_arbiter_4_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arbState_e          r_state, w_stateNext;
  logic [IDX_W-1:0]   r_owner, w_ownerNext;
  logic [IDX_W-1:0]   r_ptr, w_ptrNext;
  logic [CNT_W-1:0]   r_holdCnt, w_holdCntNext;
  logic [N_REQ_C-1:0] r_gnt, w_gntNext;
  logic [IDX_W-1:0]   r_gntId, w_gntIdNext;
  logic               r_gntValid;
  logic               r_timeout, w_timeoutNext;
  logic               w_any;
  logic [IDX_W_C-1:0] w_pickIdx;
  logic               w_ownerReq;
  logic               w_holdDone;

  arb_pick u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .i_rr_en (bus.rr_en),
    .o_any   (w_any),
    .o_idx   (w_pickIdx)
  );

  assign w_ownerReq = bus.req[r_owner];
  // Counter holds completed GRANT cycles, so the last allowed cycle sees MAX_HOLD-1.
  assign w_holdDone = (MAX_HOLD > 0) && (r_holdCnt == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_ptr      <= IDX_W'(N_REQ - 1);
      r_holdCnt  <= '0;
      r_gnt      <= '0;
      r_gntId    <= '0;
      r_gntValid <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_owner    <= w_ownerNext;
      r_ptr      <= w_ptrNext;
      r_holdCnt  <= w_holdCntNext;
      r_gnt      <= w_gntNext;
      r_gntId    <= w_gntIdNext;
      r_gntValid <= |w_gntNext;
      r_timeout  <= w_timeoutNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_ownerNext   = r_owner;
    w_ptrNext     = r_ptr;
    w_holdCntNext = r_holdCnt;
    unique case (r_state)
      IDLE, RELEASE: begin
        if (w_any) begin
          w_stateNext   = GRANT;
          w_ownerNext   = w_pickIdx;
          w_holdCntNext = '0;
        end else begin
          w_stateNext = IDLE;
        end
      end
      GRANT: begin
        if (!w_ownerReq || w_holdDone) begin
          w_stateNext = RELEASE;
          w_ptrNext   = r_owner;
        end else begin
          w_holdCntNext = r_holdCnt + 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // A GRANT exit with the owner still requesting can only be the hold limit.
  always_comb begin
    w_gntNext     = '0;
    w_gntIdNext   = '0;
    w_timeoutNext = (r_state == GRANT) && (w_stateNext == RELEASE) && w_ownerReq;
    if (w_stateNext == GRANT) begin
      w_gntNext   = oneHot(w_ownerNext);
      w_gntIdNext = w_ownerNext;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_gntId;
  assign bus.gnt_valid = r_gntValid;
  assign bus.timeout   = r_timeout;

endmodule
